// File: rtl/stall_memory_pkg.sv
// rtl/stall_memory_pkg.sv - shared types and constants for the stalling word memory
package stall_memory_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEFAULT_DEPTH = 48;
   localparam int MAX_LATENCY   = 15;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

endpackage

// File: rtl/stall_memory_array.sv
// rtl/stall_memory_array.sv - byte-enable word array with offset/range decode
module stall_memory_array
   import stall_memory_pkg::*;
#(
   parameter int WORD_DEPTH = DEFAULT_DEPTH,
   parameter int ADDR_W     = 32
) (
   input  logic              clk_i,
   input  logic [ADDR_W-1:0] offset_i,
   input  logic              acc_i,
   input  logic              wen_i,
   input  logic [3:0]        be_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output rsp_t              look_o
);
   localparam int IDX_W = (WORD_DEPTH < 2) ? 1 : $clog2(WORD_DEPTH);

   logic [31:0]       mem [WORD_DEPTH];
   logic [ADDR_W-1:0] diff;
   logic [ADDR_W-1:0] idx;
   logic [IDX_W-1:0]  widx;
   logic              err;

   assign diff = addr_i - offset_i;
   assign idx  = diff >> 2;
   assign widx = idx[IDX_W-1:0];
   assign err  = (addr_i[1:0] != 2'b00) || (addr_i < offset_i) ||
                 (idx >= ADDR_W'(WORD_DEPTH));

   // Response data is what the word holds before this edge's write lands.
   always_comb begin
      look_o.err   = err;
      look_o.rdata = (wen_i || err) ? 32'h0 : mem[widx];
   end

   always_ff @(posedge clk_i) begin
      if (acc_i && wen_i && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem[widx][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/stall_memory.sv
// rtl/stall_memory.sv - single-outstanding request/response FSM with fixed latency
module stall_memory
   import stall_memory_pkg::*;
#(
   parameter int WORD_DEPTH = DEFAULT_DEPTH,
   parameter int LATENCY    = 1,
   parameter int ADDR_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] offset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_wen_i,
   input  logic [3:0]        req_be_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o
);
   localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   rsp_t             rsp_q, rsp_d;
   rsp_t             look;
   logic             acc;

   stall_memory_array #(
      .WORD_DEPTH(WORD_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_array (
      .clk_i   (clk_i),
      .offset_i(offset_i),
      .acc_i   (acc & ~rst_i),
      .wen_i   (req_wen_i),
      .be_i    (req_be_i),
      .addr_i  (req_addr_i),
      .wdata_i (req_wdata_i),
      .look_o  (look)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_d       = rsp_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      acc         = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            acc         = req_valid_i;
            if (req_valid_i) begin
               rsp_d = look;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
               rsp_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rsp_q   <= rsp_d;
      end
   end

   assign rsp_rdata_o = rsp_q.rdata;
   assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_stall_memory.sv
// tb/tb_stall_memory.sv - checks stall_memory at latencies 1, 2, 3 and 8
module tb_stall_memory;
   localparam logic [31:0] OFF   = 32'h0001_0000;
   localparam int          DEPTH = 48;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] offset;
   logic        req_valid, req_wen, rsp_ready;
   logic [3:0]  req_be;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready [4];
   logic        rsp_valid [4];
   logic        rsp_err   [4];
   logic [31:0] rsp_rdata [4];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mdl [DEPTH];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stall_memory #(.WORD_DEPTH(DEPTH), .LATENCY(1), .ADDR_W(32)) d0 (
      .clk_i(clk), .rst_i(rst), .offset_i(offset), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
      .req_wen_i(req_wen), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]));
   stall_memory #(.WORD_DEPTH(DEPTH), .LATENCY(2), .ADDR_W(32)) d1 (
      .clk_i(clk), .rst_i(rst), .offset_i(offset), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
      .req_wen_i(req_wen), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]));
   stall_memory #(.WORD_DEPTH(DEPTH), .LATENCY(3), .ADDR_W(32)) d2 (
      .clk_i(clk), .rst_i(rst), .offset_i(offset), .req_valid_i(req_valid), .req_ready_o(req_ready[2]),
      .req_wen_i(req_wen), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]));
   stall_memory #(.WORD_DEPTH(DEPTH), .LATENCY(8), .ADDR_W(32)) d3 (
      .clk_i(clk), .rst_i(rst), .offset_i(offset), .req_valid_i(req_valid), .req_ready_o(req_ready[3]),
      .req_wen_i(req_wen), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid[3]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[3]), .rsp_err_o(rsp_err[3]));

   typedef struct {
      logic        wen;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t vt [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic mem_set(input int s, input int i, input logic [31:0] v);
      case (s)
         0: d0.u_array.mem[i] = v;
         1: d1.u_array.mem[i] = v;
         2: d2.u_array.mem[i] = v;
         default: d3.u_array.mem[i] = v;
      endcase
   endtask

   function automatic logic [31:0] mem_get(input int s, input int i);
      case (s)
         0: return d0.u_array.mem[i];
         1: return d1.u_array.mem[i];
         2: return d2.u_array.mem[i];
         default: return d3.u_array.mem[i];
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Issues one request to instance s; lat counts edges from accept to first rsp_valid sample.
   task automatic txn(input int s, input logic wen, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output int acc_cyc, output int rdy_bad);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_wen = wen; req_be = be; req_addr = addr; req_wdata = wd;
      n = 0;
      while (!req_ready[s] && n < 100) begin
         @(negedge clk);
         n++;
      end
      acc_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; rdy_bad = 0;
      while (!rsp_valid[s] && lat < 100) begin
         if (req_ready[s]) rdy_bad++;
         @(negedge clk);
         lat++;
      end
      if (req_ready[s]) rdy_bad++;
      rd = rsp_rdata[s];
      er = rsp_err[s];
   endtask

   function automatic logic model_err(input logic [31:0] a);
      longint d;
      d = longint'(a) - longint'(OFF);
      return (a % 4 != 0) || (d < 0) || (d / 4 >= DEPTH);
   endfunction

   initial begin
      logic [31:0] rd, v0, a, wd;
      logic        er, e0, w;
      logic [3:0]  be;
      int          lat, ac, prev_ac, rb, bad, idx;

      rst = 1'b1; offset = OFF; req_valid = 1'b0; req_wen = 1'b0; req_be = 4'h0;
      req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         chk($sformatf("reset_ready%0d", s), 32'(req_ready[s]), 32'd1);
         chk($sformatf("reset_valid%0d", s), 32'(rsp_valid[s]), 32'd0);
         chk($sformatf("reset_rdata%0d", s), rsp_rdata[s], 32'd0);
         chk($sformatf("reset_err%0d", s), 32'(rsp_err[s]), 32'd0);
      end
      rst = 1'b0;

      // Basic read, LATENCY=3
      do_reset();
      mem_set(2, 2, 32'hDEADBEEF);
      txn(2, 1'b0, 4'h0, OFF + 32'h8, 32'h0, rd, er, lat, ac, rb);
      chk("l3_latency", 32'(lat), 32'd3);
      chk("l3_rdata", rd, 32'hDEADBEEF);
      chk("l3_err", 32'(er), 32'd0);
      chk("l3_ready_low", 32'(rb), 32'd0);

      // Table: byte enables, errors and boundaries on LATENCY=1
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         mdl[i] = 32'h1000_0000 + 32'(i);
         mem_set(0, i, mdl[i]);
      end
      mdl[0] = 32'h11223344;
      mem_set(0, 0, mdl[0]);
      vt[0]  = '{1'b1, 4'b0101, OFF,           32'hAABBCCDD, 32'h0,         1'b0};
      vt[1]  = '{1'b0, 4'b0000, OFF,           32'h0,        32'h11BB33DD,  1'b0};
      vt[2]  = '{1'b0, 4'b0000, OFF + 32'hC0,  32'h0,        32'h0,         1'b1};
      vt[3]  = '{1'b0, 4'b0000, OFF + 32'h2,   32'h0,        32'h0,         1'b1};
      vt[4]  = '{1'b1, 4'b1111, OFF - 32'h4,   32'hFFFFFFFF, 32'h0,         1'b1};
      vt[5]  = '{1'b0, 4'b0000, OFF + 32'hBC,  32'h0,        32'h1000002F,  1'b0};
      vt[6]  = '{1'b1, 4'b1000, OFF + 32'hBC,  32'h77665544, 32'h0,         1'b0};
      vt[7]  = '{1'b0, 4'b0000, OFF + 32'hBC,  32'h0,        32'h7700002F,  1'b0};
      vt[8]  = '{1'b1, 4'b1111, OFF + 32'hBD,  32'h12345678, 32'h0,         1'b1};
      vt[9]  = '{1'b1, 4'b1111, OFF + 32'hC0,  32'h12345678, 32'h0,         1'b1};
      vt[10] = '{1'b0, 4'b0000, 32'h0,         32'h0,        32'h0,         1'b1};
      for (int i = 0; i < 11; i++) begin
         txn(0, vt[i].wen, vt[i].be, vt[i].addr, vt[i].wdata, rd, er, lat, ac, rb);
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
         chk($sformatf("vec%0d_ready_low", i), 32'(rb), 32'd0);
      end
      mdl[0]  = 32'h11BB33DD;
      mdl[47] = 32'h7700002F;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem_get(0, i) !== mdl[i]) bad++;
      chk("array_words_unexpected", 32'(bad), 32'd0);

      // Backpressure, LATENCY=2
      do_reset();
      mem_set(1, 5, 32'hCAFEF00D);
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_be = 4'h0; req_addr = OFF + 32'h14;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid[1] && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", 32'(lat), 32'd2);
      v0 = rsp_rdata[1]; e0 = rsp_err[1];
      chk("bp_rdata", v0, 32'hCAFEF00D);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!rsp_valid[1] || rsp_rdata[1] !== v0 || rsp_err[1] !== e0 || req_ready[1]) bad++;
      end
      chk("bp_frozen", 32'(bad), 32'd0);
      rsp_ready = 1'b1; req_valid = 1'b1;
      chk("bp_no_accept_in_resp", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
      chk("bp_ready_after_handshake", 32'(req_ready[1]), 32'd1);
      chk("bp_valid_cleared", 32'(rsp_valid[1]), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_second_accepted", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
      chk("bp_second_rsp", 32'(rsp_valid[1]), 32'd1);
      chk("bp_second_rdata", rsp_rdata[1], 32'hCAFEF00D);

      // Reset mid-WAIT, LATENCY=8
      do_reset();
      mem_set(3, 4, 32'h0);
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_be = 4'hF; req_addr = OFF + 32'h10; req_wdata = 32'h5;
      chk("rst_pre_ready", 32'(req_ready[3]), 32'd1);
      bad = 0;
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid[3]) bad++;
      @(negedge clk);
      if (rsp_valid[3]) bad++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_ready_immediate", 32'(req_ready[3]), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rsp_valid[3]) bad++;
      end
      chk("rst_no_rsp_valid", 32'(bad), 32'd0);
      txn(3, 1'b0, 4'h0, OFF + 32'h10, 32'h0, rd, er, lat, ac, rb);
      chk("rst_write_kept", rd, 32'h5);
      chk("rst_read_latency", 32'(lat), 32'd8);

      // Random back-to-back stream, LATENCY=1
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         mdl[i] = $urandom;
         mem_set(0, i, mdl[i]);
      end
      prev_ac = 0;
      for (int t = 0; t < 20; t++) begin
         w   = 1'($urandom_range(0, 1));
         be  = 4'($urandom_range(0, 15));
         wd  = $urandom;
         idx = $urandom_range(0, 7);
         case ($urandom_range(0, 9))
            0:       a = OFF + 32'(4 * $urandom_range(48, 60));
            1:       a = OFF + 32'(4 * idx) + 32'($urandom_range(1, 3));
            2:       a = OFF - 32'(4 * $urandom_range(1, 4));
            default: a = OFF + 32'(4 * idx);
         endcase
         txn(0, w, be, a, wd, rd, er, lat, ac, rb);
         chk($sformatf("rnd%0d_err", t), 32'(er), 32'(model_err(a)));
         if (w || model_err(a)) begin
            chk($sformatf("rnd%0d_rdata", t), rd, 32'h0);
         end else begin
            chk($sformatf("rnd%0d_rdata", t), rd, mdl[(a - OFF) / 4]);
         end
         if (w && !model_err(a)) begin
            for (int b = 0; b < 4; b++) if (be[b]) mdl[(a - OFF) / 4][b*8 +: 8] = wd[b*8 +: 8];
         end
         chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'd1);
         if (t > 0) chk($sformatf("rnd%0d_spacing", t), 32'(ac - prev_ac), 32'd2);
         prev_ac = ac;
      end
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem_get(0, i) !== mdl[i]) bad++;
      chk("rnd_array_contents", 32'(bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
